button_ctrl: RTL and testbench

- Memory-mapped button input peripheral on the common memory bus, directly upstream of the top-level button read path.
- Synchronises and debounces raw button pins, holds sticky rising/falling edge flags and drives an interrupt request.
- Single-cycle bus slave with the same bus handshake as the other peripherals; occupies 16 bytes (4 word registers).

---
 rtl/button_ctrl.sv | 142 ++++++++++++++
 tb/tb_button_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_ctrl.sv
// Button input peripheral: two-flop synchroniser and per-bit debounce, sticky
// rise/fall flags with write-1-to-clear, interrupt enable and a registered
// level interrupt. Single-cycle bus slave decoding address bits [3:2].
module button_ctrl #(
    parameter int unsigned BUTTONCOUNT     = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BUTTONCOUNT-1:0] buttons_in,
    input  logic [31:0]            address_in,
    input  logic                   sel_in,
    input  logic                   read_in,
    output logic [31:0]            read_value_out,
    input  logic [3:0]             write_mask_in,
    input  logic [31:0]            write_value_in,
    output logic                   ready_out,
    output logic                   irq_out
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] REG_STATE  = 2'd0;
    localparam logic [1:0] REG_RISE   = 2'd1;
    localparam logic [1:0] REG_FALL   = 2'd2;
    localparam logic [1:0] REG_IRQ_EN = 2'd3;

    logic [BUTTONCOUNT-1:0]            sync1_q;
    logic [BUTTONCOUNT-1:0]            sync2_q;
    logic [BUTTONCOUNT-1:0]            stable_q;
    logic [BUTTONCOUNT-1:0]            stable_d;
    logic [BUTTONCOUNT-1:0][CNT_W-1:0] cnt_q;
    logic [BUTTONCOUNT-1:0][CNT_W-1:0] cnt_d;
    logic [BUTTONCOUNT-1:0]            rise_q;
    logic [BUTTONCOUNT-1:0]            rise_d;
    logic [BUTTONCOUNT-1:0]            fall_q;
    logic [BUTTONCOUNT-1:0]            fall_d;
    logic [BUTTONCOUNT-1:0]            irq_en_q;
    logic [BUTTONCOUNT-1:0]            irq_en_d;
    logic                              irq_q;
    logic                              irq_d;

    logic                              wr_en;
    logic [1:0]                        reg_sel;
    logic [BUTTONCOUNT-1:0]            wr_bits;
    logic [BUTTONCOUNT-1:0]            rise_set;
    logic [BUTTONCOUNT-1:0]            fall_set;
    logic [BUTTONCOUNT-1:0]            rise_clr;
    logic [BUTTONCOUNT-1:0]            fall_clr;
    logic                              unused_bus;

    // Only the low byte lane and address bits [3:2] matter; reads have no side effects.
    assign unused_bus = ^{read_in, address_in, write_mask_in, write_value_in};

    assign reg_sel = address_in[3:2];
    assign wr_en   = sel_in & write_mask_in[0];
    assign wr_bits = write_value_in[BUTTONCOUNT-1:0];

    // Synchroniser: sync1 feeds sync2 directly with no logic between them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= buttons_in;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept the synchronised level after DEBOUNCE_CYCLES consecutive disagreements.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < int'(BUTTONCOUNT); i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Flag, enable and interrupt next state; a flag set beats a same-cycle clear.
    always_comb begin
        rise_set = stable_d & ~stable_q;
        fall_set = ~stable_d & stable_q;
        rise_clr = '0;
        fall_clr = '0;
        irq_en_d = irq_en_q;
        if (wr_en) begin
            case (reg_sel)
                REG_RISE:   rise_clr = wr_bits;
                REG_FALL:   fall_clr = wr_bits;
                REG_IRQ_EN: irq_en_d = wr_bits;
                default:    ;
            endcase
        end
        rise_d = (rise_q & ~rise_clr) | rise_set;
        fall_d = (fall_q & ~fall_clr) | fall_set;
        irq_d  = |((rise_q | fall_q) & irq_en_q);
    end

    // State registers for debounce, flags, enables and the interrupt line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_q <= '0;
            cnt_q    <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_out   = irq_q;
    assign ready_out = sel_in & reset;

    // Zero-wait-state read mux; idle bus and reset both return zero.
    always_comb begin
        read_value_out = '0;
        if (sel_in && reset) begin
            case (reg_sel)
                REG_STATE:  read_value_out = 32'(stable_q);
                REG_RISE:   read_value_out = 32'(rise_q);
                REG_FALL:   read_value_out = 32'(fall_q);
                REG_IRQ_EN: read_value_out = 32'(irq_en_q);
                default:    read_value_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_button_ctrl.sv
// Bench for button_ctrl with DEBOUNCE_CYCLES=4: directed sequences, a bus
// vector table and randomized traffic against a window-based reference model.
module tb_button_ctrl;

    localparam int NB = 4;
    localparam int D  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  btn = 4'h0;
    logic [31:0] addr = '0;
    logic        sel = 1'b0;
    logic        rd_strobe = 1'b0;
    logic [3:0]  wmask = '0;
    logic [31:0] wdata = '0;
    logic [31:0] read_value_out;
    logic        ready_out;
    logic        irq_out;

    int checks   = 0;
    int failures = 0;

    button_ctrl #(.BUTTONCOUNT(NB), .DEBOUNCE_CYCLES(D)) dut (
        .clk            (clk),
        .reset          (rst_n),
        .buttons_in     (btn),
        .address_in     (addr),
        .sel_in         (sel),
        .read_in        (rd_strobe),
        .read_value_out (read_value_out),
        .write_mask_in  (wmask),
        .write_value_in (wdata),
        .ready_out      (ready_out),
        .irq_out        (irq_out)
    );

    always #5 clk = ~clk;

    // Reference model: stable level follows the synchronised pin once it has
    // differed from the stable level on D consecutive edges.
    logic [3:0] m_stable, m_rise, m_fall, m_en;
    logic       m_irq;
    logic [3:0] cap[$];
    int         t;

    function automatic logic s_at(int u, int i);
        logic [3:0] v;
        if (u < 3) return 1'b0;
        v = cap[u-2];
        return v[i];
    endfunction

    task automatic model_reset();
        m_stable = '0; m_rise = '0; m_fall = '0; m_en = '0; m_irq = 1'b0;
        cap.delete();
        cap.push_back(4'h0);
        t = 0;
    endtask

    task automatic model_edge();
        logic [3:0] ns, clr_r, clr_f, en_n;
        logic       irq_n;
        int         first;
        bit         all;
        t++;
        cap.push_back(btn);
        ns = m_stable;
        first = t - D + 1;
        for (int i = 0; i < NB; i++) begin
            if (first >= 1) begin
                all = 1'b1;
                for (int u = first; u <= t; u++)
                    if (s_at(u, i) == m_stable[i]) all = 1'b0;
                if (all) ns[i] = ~m_stable[i];
            end
        end
        clr_r = '0; clr_f = '0; en_n = m_en;
        if (sel && wmask[0]) begin
            if (addr[3:2] == 2'd1) clr_r = wdata[3:0];
            if (addr[3:2] == 2'd2) clr_f = wdata[3:0];
            if (addr[3:2] == 2'd3) en_n  = wdata[3:0];
        end
        irq_n    = |((m_rise | m_fall) & m_en);
        m_rise   = (m_rise & ~clr_r) | (ns & ~m_stable);
        m_fall   = (m_fall & ~clr_f) | (~ns & m_stable);
        m_en     = en_n;
        m_stable = ns;
        m_irq    = irq_n;
    endtask

    function automatic logic [31:0] model_read();
        logic [1:0] a;
        if (!(sel && rst_n)) return 32'h0;
        a = addr[3:2];
        case (a)
            2'd0:    return {28'h0, m_stable};
            2'd1:    return {28'h0, m_rise};
            2'd2:    return {28'h0, m_fall};
            default: return {28'h0, m_en};
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock with current inputs; outputs compared against the model before the edge.
    task automatic cycle(int n);
        for (int k = 0; k < n; k++) begin
            #1;
            chk("ready", 32'(ready_out), 32'(sel & rst_n));
            chk("read", read_value_out, model_read());
            chk("irq", 32'(irq_out), 32'(m_irq));
            @(posedge clk);
            model_edge();
            #1;
        end
    endtask

    task automatic idle();
        sel = 1'b0; addr = '0; wmask = '0; wdata = '0;
    endtask

    task automatic rd(logic [31:0] a, logic [31:0] exp, string name);
        sel = 1'b1; addr = a; wmask = '0; wdata = '0;
        #1;
        chk(name, read_value_out, exp);
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d);
        sel = 1'b1; addr = a; wmask = 4'h1; wdata = d;
        cycle(1);
        idle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sel = 1'b1; addr = '0; wmask = '0; wdata = '0;
        #1;
        chk("rst_read_sel", read_value_out, 32'h0);
        chk("rst_ready_sel", 32'(ready_out), 32'h0);
        chk("rst_irq", 32'(irq_out), 32'h0);
        sel = 1'b0;
        #1;
        chk("rst_read_nosel", read_value_out, 32'h0);
        chk("rst_ready_nosel", 32'(ready_out), 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_irq_held", 32'(irq_out), 32'h0);
        chk("rst_read_held", read_value_out, 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic clean();
        idle();
        btn = 4'h0;
        cycle(8);
        wr(32'h4, 32'hF);
        wr(32'h8, 32'hF);
        wr(32'hC, 32'h0);
    endtask

    typedef struct {
        logic        sel;
        logic [31:0] addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic        exp_ready;
        logic [31:0] exp_op_rd;
        logic [31:0] rd_addr;
        logic [31:0] exp_rd;
    } bus_vec_t;

    bus_vec_t tbl[9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0, 32'h00, 4'h0, 32'h0,        1'b0, 32'h0, 32'hC, 32'h0};
        tbl[1] = '{1'b1, 32'h0C, 4'h1, 32'h5,        1'b1, 32'h0, 32'hC, 32'h5};
        tbl[2] = '{1'b1, 32'h0C, 4'h2, 32'hA,        1'b1, 32'h5, 32'hC, 32'h5};
        tbl[3] = '{1'b1, 32'h00, 4'hF, 32'hF,        1'b1, 32'h0, 32'h0, 32'h0};
        tbl[4] = '{1'b0, 32'h0C, 4'h1, 32'h0,        1'b0, 32'h0, 32'hC, 32'h5};
        tbl[5] = '{1'b1, 32'h0C, 4'h1, 32'hFFFFFFF0, 1'b1, 32'h5, 32'hC, 32'h0};
        tbl[6] = '{1'b1, 32'h1C, 4'h1, 32'h3,        1'b1, 32'h0, 32'hC, 32'h3};
        tbl[7] = '{1'b1, 32'h04, 4'h1, 32'hF,        1'b1, 32'h0, 32'h4, 32'h0};
        tbl[8] = '{1'b1, 32'h0C, 4'h1, 32'h0,        1'b1, 32'h3, 32'hC, 32'h0};

        model_reset();
        #1;

        // Reset with all buttons held, then debounce from stable=0.
        btn = 4'hF;
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            cycle(1);
            rd(32'h0, (k >= 6) ? 32'hF : 32'h0, $sformatf("rst_state_k%0d", k));
        end
        rd(32'h4, 32'hF, "rst_rise");
        idle();
        clean();

        // Short pulse is rejected; a held press is accepted exactly on time.
        btn = 4'h1;
        cycle(3);
        btn = 4'h0;
        cycle(8);
        rd(32'h0, 32'h0, "glitch_state");
        rd(32'h4, 32'h0, "glitch_rise");
        idle();
        btn = 4'h1;
        for (int k = 1; k <= 7; k++) begin
            cycle(1);
            rd(32'h0, (k >= 6) ? 32'h1 : 32'h0, $sformatf("hold_state_k%0d", k));
        end
        rd(32'h4, 32'h1, "hold_rise");
        idle();

        // W1C of RISE, then FALL after release; zero write leaves FALL alone.
        wr(32'h4, 32'h1);
        rd(32'h4, 32'h0, "w1c_rise");
        idle();
        btn = 4'h0;
        cycle(7);
        rd(32'h8, 32'h1, "fall_set");
        idle();
        wr(32'h8, 32'h0);
        rd(32'h8, 32'h1, "fall_w0");
        idle();
        wr(32'h8, 32'h1);
        rd(32'h8, 32'h0, "fall_w1c");
        idle();

        // Interrupt enable masks sources; irq lags the flags by one cycle.
        wr(32'hC, 32'h2);
        btn = 4'h2;
        cycle(5);
        rd(32'h4, 32'h0, "irq_rise_before");
        chk("irq_before", 32'(irq_out), 32'h0);
        cycle(1);
        rd(32'h4, 32'h2, "irq_rise_set");
        chk("irq_same_cycle", 32'(irq_out), 32'h0);
        idle();
        cycle(1);
        chk("irq_asserted", 32'(irq_out), 32'h1);
        btn = 4'h3;
        cycle(7);
        rd(32'h4, 32'h3, "irq_rise_both");
        chk("irq_still", 32'(irq_out), 32'h1);
        idle();
        wr(32'h4, 32'h2);
        chk("irq_clr_edge", 32'(irq_out), 32'h1);
        rd(32'h4, 32'h1, "irq_rise_after_clr");
        idle();
        cycle(1);
        chk("irq_deasserted", 32'(irq_out), 32'h0);
        cycle(2);
        chk("irq_btn0_masked", 32'(irq_out), 32'h0);
        clean();

        // W1C lands on the same edge that sets RISE[2]: set wins.
        btn = 4'h4;
        cycle(5);
        wr(32'h4, 32'h4);
        rd(32'h4, 32'h4, "collision_rise");
        idle();
        clean();

        // Bus vector table.
        for (int v = 0; v < 9; v++) begin
            sel = tbl[v].sel; addr = tbl[v].addr; wmask = tbl[v].wmask; wdata = tbl[v].wdata;
            #1;
            chk($sformatf("tbl%0d_ready", v), 32'(ready_out), 32'(tbl[v].exp_ready));
            chk($sformatf("tbl%0d_op_read", v), read_value_out, tbl[v].exp_op_rd);
            cycle(1);
            rd(tbl[v].rd_addr, tbl[v].exp_rd, $sformatf("tbl%0d_result", v));
            idle();
        end

        // Reset in the middle of a debounce; the held button is re-debounced.
        btn = 4'h1;
        cycle(3);
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            cycle(1);
            rd(32'h0, (k >= 6) ? 32'h1 : 32'h0, $sformatf("midrst_state_k%0d", k));
        end
        rd(32'h4, 32'h1, "midrst_rise");
        idle();

        // Randomized button and bus traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 5) == 0) btn ^= 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                sel   = 1'b1;
                addr  = $urandom();
                wmask = 4'($urandom_range(0, 15));
                wdata = $urandom();
            end else begin
                idle();
            end
            rd_strobe = 1'($urandom_range(0, 1));
            cycle(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
